fifo_wptr_full: RTL and testbench
=================================

FIFO_WPTR_FULL -- requirements
Module: fifo_wptr_full

Interface
REQ-001 SHALL have parameter ASIZE, default 4, address width; FIFO depth is 2^ASIZE; legal range ASIZE >= 2.
REQ-002 SHALL have parameter AFULL_THRESH, default 12, almost-full level in entries; legal range 1..2^ASIZE.
REQ-003 SHALL have port src_clk, input, 1, the single clock; all state is updated on its rising edge.
REQ-004 SHALL have port src_rst_n, input, 1, reset; it is asynchronous and active-low.
REQ-005 SHALL have port wr_en, input, 1, write request.
REQ-006 SHALL have port rptr_sync, input, ASIZE+1, Gray-coded read pointer already synchronized into the src_clk domain.
REQ-007 SHALL have port ovf_clr, input, 1, clears the sticky overflow flag.
REQ-008 SHALL have port wr_accept, output, 1, write accepted this cycle (combinational).
REQ-009 SHALL have port waddr, output, ASIZE, binary write address to the storage RAM.
REQ-010 SHALL have port wptr, output, ASIZE+1, registered Gray write pointer, sent to the read-domain synchronizer.
REQ-011 SHALL have port full, output, 1, registered FIFO-full flag.
REQ-012 SHALL have port almost_full, output, 1, registered; asserted when level >= AFULL_THRESH.
REQ-013 SHALL have port wr_level, output, ASIZE+1, registered occupancy as seen from the write side.
REQ-014 SHALL have port overflow, output, 1, sticky flag: a write was attempted while full.

Function
REQ-015 SHALL hold an internal binary pointer wbin of width ASIZE+1.
REQ-016 SHALL drive wr_accept = wr_en AND NOT full.
REQ-017 SHALL compute wbin_next = wbin + wr_accept, wrapping modulo 2^(ASIZE+1); wbin updates to wbin_next every edge.
REQ-018 SHALL compute wgray_next = wbin_next XOR (wbin_next >> 1) and register it into wptr every edge.
REQ-019 SHALL drive waddr = wbin[ASIZE-1:0]: the address of the current write, valid in the cycle wr_accept is high.
REQ-020 SHALL ensure wptr changes in at most one bit per clock, including at the wrap from 2^(ASIZE+1)-1 to 0.
REQ-021 SHALL register full <= (wgray_next == {~rptr_sync[ASIZE:ASIZE-1], rptr_sync[ASIZE-2:0]}).
REQ-022 SHALL assert full on the same edge that accepts the write which fills the FIFO, with zero-cycle pessimism on assertion.
REQ-023 SHALL deassert full only on the first edge after rptr_sync shows a freed entry; this conservative release is required behaviour.
REQ-024 SHALL convert rptr_sync Gray to binary rbin combinationally, where bit i is the XOR of rptr_sync[ASIZE:i].
REQ-025 SHALL register wr_level <= (wbin_next - rbin) mod 2^(ASIZE+1); the result always lies in 0..2^ASIZE.
REQ-026 SHALL register almost_full <= (wbin_next - rbin) >= AFULL_THRESH, using the same edge timing as wr_level.
REQ-027 SHALL ignore a write while full: wbin, wptr and waddr hold, and overflow sets on that edge.
REQ-028 SHALL clear overflow on an edge where ovf_clr = 1; if a set condition and ovf_clr occur together, set wins.
REQ-029 SHALL never decrement wbin and SHALL never read or modify rptr_sync state.

Reset
REQ-030 SHALL, while src_rst_n = 0 and without waiting for a clock edge, force wbin, wptr, full, almost_full, wr_level and overflow to 0; waddr therefore reads 0.
REQ-031 SHALL restart from pointer 0 on the first edge after src_rst_n deasserts; an assertion in the middle of a write burst discards that burst.

Verification (ASIZE=4, AFULL_THRESH=12)
REQ-032 Reset with wr_en=1 held -> all outputs 0 while reset is low; first write after release gives waddr=0.
REQ-033 rptr_sync=0, 16 writes -> after 16th edge: full=1, wptr=5'b11000, wr_level=16, waddr=0; 12th edge sets almost_full=1.
REQ-034 17th write while full -> wr_accept=0, wptr unchanged, overflow=1; ovf_clr pulse -> overflow=0; ovf_clr together with a write while full -> overflow stays 1.
REQ-035 From full, set rptr_sync=5'b00001 -> next edge: full=0, wr_level=15, almost_full=1.
REQ-036 40 writes with rptr_sync tracking 2 entries behind -> each wptr change has Hamming distance 1; at wrap wptr goes 5'b10000 -> 5'b00000.
REQ-037 Assert src_rst_n asynchronously mid-cycle at wbin=7 -> outputs 0 before the next src_clk edge.

Source files
------------

// File: rtl/fifo_wptr_full.sv
// Write-side pointer and flag logic for an asynchronous FIFO.
// Tracks the write pointer in binary and Gray, and derives full, almost-full, level and overflow from the synchronized read pointer.
module fifo_wptr_full #(
  parameter int ASIZE        = 4,
  parameter int AFULL_THRESH = 12
) (
  input  logic             src_clk,
  input  logic             src_rst_n,
  input  logic             wr_en,
  input  logic [ASIZE:0]   rptr_sync,
  input  logic             ovf_clr,
  output logic             wr_accept,
  output logic [ASIZE-1:0] waddr,
  output logic [ASIZE:0]   wptr,
  output logic             full,
  output logic             almost_full,
  output logic [ASIZE:0]   wr_level,
  output logic             overflow
);

  localparam logic [ASIZE:0] AFULL_LVL = (ASIZE+1)'(AFULL_THRESH);

  logic [ASIZE:0] wbin;
  logic [ASIZE:0] wbin_next;
  logic [ASIZE:0] wgray_next;
  logic [ASIZE:0] rbin;
  logic [ASIZE:0] level_next;
  logic [ASIZE:0] full_ptr;

  assign wr_accept  = wr_en & ~full;
  assign wbin_next  = wbin + {{ASIZE{1'b0}}, wr_accept};
  assign wgray_next = wbin_next ^ (wbin_next >> 1);
  assign waddr      = wbin[ASIZE-1:0];

  // Full when the next write pointer has lapped the read pointer by exactly one FIFO depth.
  assign full_ptr   = {~rptr_sync[ASIZE:ASIZE-1], rptr_sync[ASIZE-2:0]};

  always_comb begin
    rbin = '0;
    for (int i = 0; i <= ASIZE; i++) begin
      rbin[i] = ^(rptr_sync >> i);
    end
  end

  assign level_next = wbin_next - rbin;

  always_ff @(posedge src_clk or negedge src_rst_n) begin
    if (!src_rst_n) begin
      wbin        <= '0;
      wptr        <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
      wr_level    <= '0;
      overflow    <= 1'b0;
    end else begin
      wbin        <= wbin_next;
      wptr        <= wgray_next;
      full        <= (wgray_next == full_ptr);
      almost_full <= (level_next >= AFULL_LVL);
      wr_level    <= level_next;
      // A write attempt while full takes priority over a simultaneous clear.
      if (wr_en && full) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Scoreboard bench for fifo_wptr_full: stimulus queues expected responses, a monitor pops and compares them.
module tb_fifo_wptr_full;

  logic       src_clk;
  logic       src_rst_n;
  logic       wr_en;
  logic [4:0] rptr_sync;
  logic       ovf_clr;
  logic       wr_accept;
  logic [3:0] waddr;
  logic [4:0] wptr;
  logic       full;
  logic       almost_full;
  logic [4:0] wr_level;
  logic       overflow;

  int total = 0;
  int bad   = 0;

  localparam int M_ACC   = 1;
  localparam int M_WADDR = 2;
  localparam int M_WPTR  = 4;
  localparam int M_FULL  = 8;
  localparam int M_AF    = 16;
  localparam int M_LVL   = 32;
  localparam int M_OVF   = 64;
  localparam int M_ALL   = 127;
  localparam int M_RST   = M_ALL & ~M_ACC;
  localparam int M_NOPTR = M_ALL & ~M_WPTR;

  typedef struct {
    string      name;
    int         mask;
    logic       acc;
    logic [3:0] waddr;
    logic [4:0] wptr;
    logic       full;
    logic       afull;
    logic [4:0] level;
    logic       ovf;
    bit         ham;
    bit         is_async;
  } exp_t;

  exp_t exp_q[$];
  event probe_ev;
  logic [4:0] prev_wptr = '0;

  logic [4:0] gray_tab [0:16] = '{5'd0, 5'd1, 5'd3, 5'd2, 5'd6, 5'd7, 5'd5, 5'd4,
                                  5'd12, 5'd13, 5'd15, 5'd14, 5'd10, 5'd11, 5'd9, 5'd8, 5'd24};

  fifo_wptr_full #(.ASIZE(4), .AFULL_THRESH(12)) dut (
    .src_clk     (src_clk),
    .src_rst_n   (src_rst_n),
    .wr_en       (wr_en),
    .rptr_sync   (rptr_sync),
    .ovf_clr     (ovf_clr),
    .wr_accept   (wr_accept),
    .waddr       (waddr),
    .wptr        (wptr),
    .full        (full),
    .almost_full (almost_full),
    .wr_level    (wr_level),
    .overflow    (overflow)
  );

  initial src_clk = 1'b0;
  always #5 src_clk = ~src_clk;

  function automatic exp_t mk(string nm, int mask, logic acc, logic [3:0] wa, logic [4:0] wp,
                              logic fu, logic af, logic [4:0] lv, logic ov);
    exp_t e;
    e.name = nm; e.mask = mask; e.acc = acc; e.waddr = wa; e.wptr = wp;
    e.full = fu; e.afull = af; e.level = lv; e.ovf = ov; e.ham = 1'b0; e.is_async = 1'b0;
    return e;
  endfunction

  function automatic logic [4:0] to_gray(int n);
    logic [4:0] b;
    b = 5'(n);
    return b ^ (b >> 1);
  endfunction

  task automatic checkField(string nm, string fld, int act, int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("[TB] FAIL %s.%s got=%0h want=%0h", nm, fld, act, expv);
    end
  endtask

  task automatic checkOutput(exp_t e, logic acc_s, logic [3:0] waddr_s);
    if ((e.mask & M_ACC)   != 0) checkField(e.name, "wr_accept",   int'(acc_s),       int'(e.acc));
    if ((e.mask & M_WADDR) != 0) checkField(e.name, "waddr",       int'(waddr_s),     int'(e.waddr));
    if ((e.mask & M_WPTR)  != 0) checkField(e.name, "wptr",        int'(wptr),        int'(e.wptr));
    if ((e.mask & M_FULL)  != 0) checkField(e.name, "full",        int'(full),        int'(e.full));
    if ((e.mask & M_AF)    != 0) checkField(e.name, "almost_full", int'(almost_full), int'(e.afull));
    if ((e.mask & M_LVL)   != 0) checkField(e.name, "wr_level",    int'(wr_level),    int'(e.level));
    if ((e.mask & M_OVF)   != 0) checkField(e.name, "overflow",    int'(overflow),    int'(e.ovf));
    if (e.ham) checkField(e.name, "wptr_hamming", $countones(prev_wptr ^ wptr), 1);
    prev_wptr = wptr;
  endtask

  // Monitor: samples the combinational outputs before the edge and the registered ones just after it.
  initial begin
    exp_t cur;
    logic acc_s;
    logic [3:0] waddr_s;
    forever begin
      @(negedge src_clk or probe_ev);
      if (exp_q.size() != 0) begin
        if (exp_q[0].is_async) begin
          cur = exp_q.pop_front();
          checkOutput(cur, wr_accept, waddr);
        end else begin
          acc_s   = wr_accept;
          waddr_s = waddr;
          @(posedge src_clk);
          #1;
          cur = exp_q.pop_front();
          checkOutput(cur, acc_s, waddr_s);
        end
      end
    end
  end

  task automatic applyStimulus(input logic we, input logic [4:0] rp, input logic clr, input exp_t e);
    wr_en     = we;
    rptr_sync = rp;
    ovf_clr   = clr;
    exp_q.push_back(e);
    @(posedge src_clk);
    #2;
  endtask

  task automatic doAsyncReset(string nm);
    exp_t e;
    src_rst_n = 1'b0;
    #1;
    e = mk(nm, M_RST, 1'b0, 4'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    e.is_async = 1'b1;
    exp_q.push_back(e);
    -> probe_ev;
    @(posedge src_clk);
    #2;
    src_rst_n = 1'b1;
  endtask

  task automatic writeBurst(int n);
    for (int k = 0; k < n; k++) begin
      applyStimulus(1'b1, 5'd0, 1'b0,
                    mk($sformatf("burst%0d", k), M_ALL, 1'b1, 4'(k), gray_tab[k+1],
                       (k == 15), (k + 1 >= 12), 5'(k + 1), 1'b0));
    end
  endtask

  initial begin
    exp_t e;
    src_rst_n = 1'b0;
    wr_en     = 1'b1;
    rptr_sync = 5'd0;
    ovf_clr   = 1'b0;
    @(posedge src_clk);
    #2;

    // Reset held with a write pending: everything stays at zero.
    applyStimulus(1'b1, 5'd0, 1'b0, mk("rst0", M_RST, 1'b0, 4'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0));
    applyStimulus(1'b1, 5'd0, 1'b0, mk("rst1", M_RST, 1'b0, 4'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0));
    src_rst_n = 1'b1;

    writeBurst(16);

    applyStimulus(1'b1, 5'd0, 1'b0, mk("ovf_set",  M_ALL, 1'b0, 4'd0, 5'b11000, 1'b1, 1'b1, 5'd16, 1'b1));
    applyStimulus(1'b0, 5'd0, 1'b1, mk("ovf_clr",  M_ALL, 1'b0, 4'd0, 5'b11000, 1'b1, 1'b1, 5'd16, 1'b0));
    applyStimulus(1'b1, 5'd0, 1'b1, mk("ovf_win",  M_ALL, 1'b0, 4'd0, 5'b11000, 1'b1, 1'b1, 5'd16, 1'b1));
    applyStimulus(1'b0, 5'd0, 1'b0, mk("ovf_hold", M_ALL, 1'b0, 4'd0, 5'b11000, 1'b1, 1'b1, 5'd16, 1'b1));

    applyStimulus(1'b0, 5'b00001, 1'b0, mk("free1",   M_ALL, 1'b0, 4'd0, 5'b11000, 1'b0, 1'b1, 5'd15, 1'b1));
    applyStimulus(1'b1, 5'b00001, 1'b0, mk("refill",  M_ALL, 1'b1, 4'd0, 5'b11001, 1'b1, 1'b1, 5'd16, 1'b1));
    applyStimulus(1'b0, 5'b00001, 1'b1, mk("refclr",  M_ALL, 1'b0, 4'd1, 5'b11001, 1'b1, 1'b1, 5'd16, 1'b0));

    doAsyncReset("async_a");

    // Read pointer trails two entries behind, so every post-write level is 3.
    for (int k = 0; k < 40; k++) begin
      e = mk($sformatf("wrap%0d", k), M_NOPTR, 1'b1, 4'(k % 16), 5'd0, 1'b0, 1'b0, 5'd3, 1'b0);
      e.ham = 1'b1;
      if (k == 30) begin e.mask = M_ALL; e.wptr = 5'b10000; end
      if (k == 31) begin e.mask = M_ALL; e.wptr = 5'b00000; end
      applyStimulus(1'b1, to_gray((k + 30) % 32), 1'b0, e);
    end

    doAsyncReset("async_b");
    writeBurst(7);
    wr_en = 1'b1;
    doAsyncReset("async_mid");
    applyStimulus(1'b1, 5'd0, 1'b0, mk("restart", M_ALL, 1'b1, 4'd0, 5'd1, 1'b0, 1'b0, 5'd1, 1'b0));

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge src_clk);
    if (exp_q.size() != 0) begin
      bad++;
      total++;
      $display("[TB] FAIL drain pending=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    bad++;
    $display("[TB] FAIL watchdog pending=%0d want=0", exp_q.size());
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
